// File: rtl/lsu_ctrl.sv
// Load/store sequencer: alignment check, memory req/ready handshake, load data extension.
// Define LSU_TIMEOUT_EN to fault a request that waits TIMEOUT_CYCLES REQ cycles without mem_ready.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..256");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_e;

  state_e          state_q, state_d;
  logic            store_q, store_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic            done_q, done_d;
  logic            fault_q, fault_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [DW-1:0]   maddr_q, maddr_d;
  logic [BW-1:0]   be_q, be_d;
  logic [DW-1:0]   mwdata_q, mwdata_d;
  logic            timeout_c;

  function automatic logic legal_f(logic st, logic [2:0] f3, logic [1:0] o);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~o[0];
      3'b010:  ok = (o == 2'b00);
      3'b100:  ok = ~st;
      3'b101:  ok = ~st & ~o[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [BW-1:0] be_f(logic [2:0] f3, logic [1:0] o);
    logic [BW-1:0] be;
    case (f3[1:0])
      2'b00:   be = BW'(4'b0001 << o);
      2'b01:   be = BW'(4'b0011 << {o[1], 1'b0});
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [DW-1:0] wd_f(logic [2:0] f3, logic [DW-1:0] w);
    logic [DW-1:0] r;
    case (f3[1:0])
      2'b00:   r = {4{w[7:0]}};
      2'b01:   r = {2{w[15:0]}};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [DW-1:0] ext_f(logic [2:0] f3, logic [1:0] o, logic [DW-1:0] d);
    logic [7:0]    b;
    logic [15:0]   h;
    logic [DW-1:0] r;
    case (o)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = o[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = d;
    endcase
    return r;
  endfunction

`ifdef LSU_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;

  // Counter is zero on the first REQ cycle and counts cycles without mem_ready.
  always_comb begin
    wait_d = 8'd0;
    if (state_q == S_REQ && !mem_ready) wait_d = wait_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wait_q <= 8'd0;
    else       wait_q <= wait_d;
  end

  assign timeout_c = (state_q == S_REQ) && !mem_ready && (wait_q == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = legal_f(is_store, funct3, addr[1:0]) ? S_REQ : S_ERR;
      S_REQ: begin
        if (mem_ready)      state_d = S_DONE;
        else if (timeout_c) state_d = S_ERR;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs follow the next state; the bus is captured from the inputs on issue.
  always_comb begin
    store_d  = store_q;
    f3_d     = f3_q;
    off_d    = off_q;
    done_d   = (state_d == S_DONE) || (state_d == S_ERR);
    fault_d  = (state_d == S_ERR);
    req_d    = (state_d == S_REQ);
    rdata_d  = rdata_q;
    we_d     = 1'b0;
    maddr_d  = '0;
    be_d     = '0;
    mwdata_d = '0;
    if (state_q == S_IDLE && start) begin
      store_d = is_store;
      f3_d    = funct3;
      off_d   = addr[1:0];
    end
    if (state_q == S_IDLE && state_d == S_REQ) begin
      we_d     = is_store;
      maddr_d  = {addr[31:2], 2'b00};
      be_d     = be_f(funct3, addr[1:0]);
      mwdata_d = is_store ? wd_f(funct3, wdata) : '0;
    end else if (state_q == S_REQ && state_d == S_REQ) begin
      we_d     = we_q;
      maddr_d  = maddr_q;
      be_d     = be_q;
      mwdata_d = mwdata_q;
    end
    if (state_q == S_REQ && mem_ready && !store_q) rdata_d = ext_f(f3_q, off_q, mem_rdata);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      store_q  <= 1'b0;
      f3_q     <= 3'd0;
      off_q    <= 2'd0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      rdata_q  <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      be_q     <= '0;
      mwdata_q <= '0;
    end else begin
      store_q  <= store_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
      rdata_q  <= rdata_d;
      req_q    <= req_d;
      we_q     <= we_d;
      maddr_q  <= maddr_d;
      be_q     <= be_d;
      mwdata_q <= mwdata_d;
    end
  end

  // Stall must rise in the issue cycle itself, so it is decoded from state and start.
  assign stall     = (state_q == S_IDLE && start) || (state_q == S_REQ);
  assign done      = done_q;
  assign fault     = fault_q;
  assign rdata     = rdata_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = maddr_q;
  assign mem_be    = be_q;
  assign mem_wdata = mwdata_q;

endmodule
